// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - 640x480@60 VGA timing constants, decode record and window helper
package vga_timing_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int COLOR_W  = 10;
    localparam int CNT_W    = 10;

    localparam int H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_SYNC_START = H_ACTIVE + H_FP;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
    localparam int V_SYNC_START = V_ACTIVE + V_FP;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

    typedef struct packed {
        logic hs_n;
        logic vs_n;
        logic active;
    } timing_t;

    // Inclusive window test shared by the horizontal and vertical sync decode.
    function automatic logic in_window(input logic [CNT_W-1:0] x,
                                       input logic [CNT_W-1:0] lo,
                                       input logic [CNT_W-1:0] hi);
        return (x >= lo) && (x <= hi);
    endfunction

endpackage

// File: rtl/vga_timing_counter.sv
// rtl/vga_timing_counter.sv - free-running h/v raster counters with sync/active decode
module vga_timing_counter
    import vga_timing_pkg::*;
#(
    parameter int H_ACT = H_ACTIVE,
    parameter int H_F   = H_FP,
    parameter int H_S   = H_SYNC,
    parameter int H_B   = H_BP,
    parameter int V_ACT = V_ACTIVE,
    parameter int V_F   = V_FP,
    parameter int V_S   = V_SYNC,
    parameter int V_B   = V_BP
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    output logic [CNT_W-1:0] h_cnt_o,
    output logic [CNT_W-1:0] v_cnt_o,
    output timing_t          timing_o
);

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_ACT + H_F + H_S + H_B - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_ACT + V_F + V_S + V_B - 1);
    localparam logic [CNT_W-1:0] H_ACT_W  = CNT_W'(H_ACT);
    localparam logic [CNT_W-1:0] V_ACT_W  = CNT_W'(V_ACT);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACT + H_F);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACT + H_F + H_S - 1);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACT + V_F);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACT + V_F + V_S - 1);

    logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
    logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
    logic             h_wrap;

    assign h_wrap = (h_cnt_q == H_LAST);

    // The line counter only moves on the pixel-counter wrap, and wraps on that same edge.
    always_comb begin
        h_cnt_d = h_wrap ? '0 : h_cnt_q + 1'b1;
        v_cnt_d = v_cnt_q;
        if (h_wrap) begin
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    always_comb begin
        timing_o.hs_n   = !in_window(h_cnt_q, HS_START, HS_END);
        timing_o.vs_n   = !in_window(v_cnt_q, VS_START, VS_END);
        timing_o.active = (h_cnt_q < H_ACT_W) && (v_cnt_q < V_ACT_W);
    end

    assign h_cnt_o = h_cnt_q;
    assign v_cnt_o = v_cnt_q;

endmodule

// File: rtl/vga_sync.sv
// rtl/vga_sync.sv - VGA timing generator with pixel coordinate export and registered DAC outputs
module vga_sync
    import vga_timing_pkg::*;
#(
    parameter int H_ACT = H_ACTIVE,
    parameter int H_F   = H_FP,
    parameter int H_S   = H_SYNC,
    parameter int H_B   = H_BP,
    parameter int V_ACT = V_ACTIVE,
    parameter int V_F   = V_FP,
    parameter int V_S   = V_SYNC,
    parameter int V_B   = V_BP,
    parameter int CW    = COLOR_W
) (
    input  logic             iCLK,
    input  logic             iRST_N,
    input  logic [CW-1:0]    iRed,
    input  logic [CW-1:0]    iGreen,
    input  logic [CW-1:0]    iBlue,
    output logic [CNT_W-1:0] px,
    output logic [CNT_W-1:0] py,
    output logic [CW-1:0]    VGA_R,
    output logic [CW-1:0]    VGA_G,
    output logic [CW-1:0]    VGA_B,
    output logic             VGA_H_SYNC,
    output logic             VGA_V_SYNC,
    output logic             VGA_SYNC,
    output logic             VGA_BLANK
);

    logic [CNT_W-1:0] h_cnt, v_cnt;
    timing_t          timing;

    logic [CW-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
    logic          hs_q, vs_q, blank_q;

    vga_timing_counter #(
        .H_ACT (H_ACT), .H_F (H_F), .H_S (H_S), .H_B (H_B),
        .V_ACT (V_ACT), .V_F (V_F), .V_S (V_S), .V_B (V_B)
    ) u_timing (
        .clk_i    (iCLK),
        .rst_ni   (iRST_N),
        .h_cnt_o  (h_cnt),
        .v_cnt_o  (v_cnt),
        .timing_o (timing)
    );

    assign px = timing.active ? h_cnt : '0;
    assign py = timing.active ? v_cnt : '0;

    always_comb begin
        r_d = timing.active ? iRed   : '0;
        g_d = timing.active ? iGreen : '0;
        b_d = timing.active ? iBlue  : '0;
    end

    // Colour, sync and blank all pass through this one stage so the DAC pins stay aligned.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_q     <= '0;
            g_q     <= '0;
            b_q     <= '0;
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            blank_q <= 1'b0;
        end else begin
            r_q     <= r_d;
            g_q     <= g_d;
            b_q     <= b_d;
            hs_q    <= timing.hs_n;
            vs_q    <= timing.vs_n;
            blank_q <= timing.active;
        end
    end

    assign VGA_R      = r_q;
    assign VGA_G      = g_q;
    assign VGA_B      = b_q;
    assign VGA_H_SYNC = hs_q;
    assign VGA_V_SYNC = vs_q;
    assign VGA_BLANK  = blank_q;
    assign VGA_SYNC   = 1'b1;

endmodule

// File: tb/tb_vga_sync.sv
// tb/tb_vga_sync.sv - self-checking bench for vga_sync against an elapsed-clock raster model
module tb_vga_sync;

    // Full horizontal timing; vertical shortened so whole frames fit in the run.
    localparam int HA = 640, HF = 16, HS = 96, HB = 48;
    localparam int HT = HA + HF + HS + HB;
    localparam int VA = 20, VF = 3, VS = 2, VB = 4;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] i_r, i_g, i_b;
    logic [9:0] px, py, vga_r, vga_g, vga_b;
    logic       vga_hs, vga_vs, vga_sync, vga_blank;

    vga_sync #(
        .H_ACT (HA), .H_F (HF), .H_S (HS), .H_B (HB),
        .V_ACT (VA), .V_F (VF), .V_S (VS), .V_B (VB), .CW (10)
    ) dut (
        .iCLK       (clk),
        .iRST_N     (rst_n),
        .iRed       (i_r),
        .iGreen     (i_g),
        .iBlue      (i_b),
        .px         (px),
        .py         (py),
        .VGA_R      (vga_r),
        .VGA_G      (vga_g),
        .VGA_B      (vga_b),
        .VGA_H_SYNC (vga_hs),
        .VGA_V_SYNC (vga_vs),
        .VGA_SYNC   (vga_sync),
        .VGA_BLANK  (vga_blank)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int n;
    bit pix_mode;
    logic [9:0] e_r, e_g, e_b;
    logic       e_hs, e_vs, e_bl;

    int hs_fall [$];
    int vs_fall [$];
    int hs_low_f1, vs_low_f1, bl_high_f1, max_px, max_py;
    logic prev_hs, prev_vs;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h (clk %0d)", tag, obs, exp, n);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_px"}, px, 0);
        chk({tag, "_py"}, py, 0);
        chk({tag, "_rgb"}, {vga_r, vga_g, vga_b}, 0);
        chk({tag, "_hs"}, vga_hs, 1);
        chk({tag, "_vs"}, vga_vs, 1);
        chk({tag, "_blank"}, vga_blank, 0);
        chk({tag, "_sync"}, vga_sync, 1);
    endtask

    task automatic model_reset();
        n = 0;
        e_r = '0; e_g = '0; e_b = '0;
        e_hs = 1'b1; e_vs = 1'b1; e_bl = 1'b0;
        prev_hs = 1'b1; prev_vs = 1'b1;
    endtask

    // One pixel clock: check the DUT at the negedge, drive inputs, advance the model.
    task automatic cycle();
        int h, v;
        bit act;
        h   = n % HT;
        v   = (n / HT) % VT;
        act = (h < HA) && (v < VA);

        chk("px", px, act ? h : 0);
        chk("py", py, act ? v : 0);
        chk("vga_r", vga_r, e_r);
        chk("vga_g", vga_g, e_g);
        chk("vga_b", vga_b, e_b);
        chk("h_sync", vga_hs, e_hs);
        chk("v_sync", vga_vs, e_vs);
        chk("blank", vga_blank, e_bl);
        chk("sync_tie", vga_sync, 1);

        if (prev_hs && !vga_hs) hs_fall.push_back(n);
        if (prev_vs && !vga_vs) vs_fall.push_back(n);
        prev_hs = vga_hs;
        prev_vs = vga_vs;
        if (n >= 1 && n <= FRAME) begin
            if (!vga_hs) hs_low_f1++;
            if (!vga_vs) vs_low_f1++;
            if (vga_blank) bl_high_f1++;
            if (int'(px) > max_px) max_px = int'(px);
            if (int'(py) > max_py) max_py = int'(py);
        end

        if (pix_mode) begin
            i_r = act ? 10'(h) : 10'd0;
            i_g = act ? 10'(v) : 10'd0;
            i_b = 10'h3FF;
        end else begin
            i_r = 10'($urandom);
            i_g = 10'($urandom);
            i_b = 10'($urandom);
        end
        e_r  = act ? i_r : 10'd0;
        e_g  = act ? i_g : 10'd0;
        e_b  = act ? i_b : 10'd0;
        e_hs = !((h >= HA + HF) && (h < HA + HF + HS));
        e_vs = !((v >= VA + VF) && (v < VA + VF + VS));
        e_bl = act;

        @(posedge clk);
        n++;
        @(negedge clk);
    endtask

    initial begin
        i_r = '1; i_g = '1; i_b = '1;
        pix_mode = 1'b0;
        hs_low_f1 = 0; vs_low_f1 = 0; bl_high_f1 = 0; max_px = 0; max_py = 0;
        model_reset();

        repeat (3) @(negedge clk);
        chk_reset_vals("rst_hold");

        rst_n = 1'b1;
        while (n < FRAME + 2) cycle();

        chk("hs_first_fall", (hs_fall.size() > 0) ? hs_fall[0] : -1, 657);
        chk("line_period", (hs_fall.size() > 1) ? hs_fall[1] - hs_fall[0] : -1, HT);
        chk("hs_low_per_frame", hs_low_f1, HS * VT);
        chk("blank_high_per_frame", bl_high_f1, HA * VA);
        chk("vs_low_per_frame", vs_low_f1, VS * HT);
        chk("vs_first_fall", (vs_fall.size() > 0) ? vs_fall[0] : -1, (VA + VF) * HT + 1);
        chk("max_px", max_px, HA - 1);
        chk("max_py", max_py, VA - 1);

        pix_mode = 1'b1;
        while (n < FRAME + 7 * HT + 6) cycle();
        chk("pix_r_5", vga_r, 5);
        chk("pix_g_7", vga_g, 7);
        chk("pix_b", vga_b, 10'h3FF);
        chk("pix_blank", vga_blank, 1);
        while (n < FRAME + 7 * HT + 641) cycle();
        chk("rgb_after_640", {vga_r, vga_g, vga_b}, 0);

        while (n < 2 * FRAME + 2) cycle();
        chk("frame_period", (vs_fall.size() > 1) ? vs_fall[1] - vs_fall[0] : -1, FRAME);

        // Mid-frame reset inside hsync of line 15.
        pix_mode = 1'b0;
        while (n < 2 * FRAME + 15 * HT + 700) cycle();
        chk("pre_reset_hs_low", vga_hs, 0);
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("rst_mid_async");
        repeat (3) @(negedge clk);
        chk_reset_vals("rst_mid_hold");
        model_reset();
        rst_n = 1'b1;
        hs_fall.delete();
        while (n < 2 * HT + 10) cycle();
        chk("hs_fall_after_rst", (hs_fall.size() > 0) ? hs_fall[0] : -1, 657);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
